// File: rtl/asip_fetch_pkg.sv
// rtl/asip_fetch_pkg.sv - shared widths, NOP encoding and queue entry type for the fetch stage
package asip_fetch_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 16;

  localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [DEFAULT_INSTR_W-1:0] instr;
    logic [DEFAULT_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry shift FIFO of fetch entries; flush beats push
module fetch_queue
  import asip_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  // Entry 0 is always the head, so a pop shifts entry 1 down.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) mem_d[0] = push_data;
          else                 mem_d[1] = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          mem_d[0] = mem_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            mem_d[0] = push_data;
          end else begin
            mem_d[0] = mem_q[1];
            mem_d[1] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) count_q <= 2'd0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign head  = mem_q[0];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generation, credit-based imem issue and decode-facing output queue
module fetch_stage
  import asip_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus1
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;

  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              flush;
  logic [2:0]        occupancy;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Slots already promised: stored entries plus the response in flight, minus what leaves now.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req  = pc_write_en && !redirect_valid && !reset && (occupancy < 3'(DEPTH));
  assign imem_addr = pc_q;

  assign push             = inflight_q && !squash_q;
  assign flush            = reset || redirect_valid;
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = req_pc_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    squash_d   = redirect_valid && inflight_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

  assign instruction = out_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = head.pc;
  assign pc_plus1    = head.pc + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_pc_write_en, a_redirect_valid, a_out_ready;
  logic [15:0] a_redirect_pc;
  logic        a_imem_req, a_out_valid;
  logic [15:0] a_imem_addr, a_imem_rdata, a_instruction, a_instr_pc, a_pc_plus1;

  logic        b_reset, b_pc_write_en, b_out_ready;
  logic        b_imem_req, b_out_valid;
  logic [15:0] b_imem_addr, b_imem_rdata, b_instruction, b_instr_pc, b_pc_plus1;

  int tests = 0;
  int fails = 0;

  fetch_stage dut_a (
    .clk(clk), .reset(a_reset), .pc_write_en(a_pc_write_en),
    .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
    .imem_req(a_imem_req), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .instruction(a_instruction),
    .instr_pc(a_instr_pc), .pc_plus1(a_pc_plus1)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .reset(b_reset), .pc_write_en(b_pc_write_en),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .instruction(b_instruction),
    .instr_pc(b_instr_pc), .pc_plus1(b_pc_plus1)
  );

  // Instruction memory: word at addr holds 0x1000+addr, garbage when not read.
  always @(posedge clk) begin
    a_imem_rdata <= a_imem_req ? 16'(16'h1000 + a_imem_addr) : 16'hDEAD;
    b_imem_rdata <= b_imem_req ? 16'(16'h1000 + b_imem_addr) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_pc_write_en = 1'b1; a_redirect_valid = 1'b0;
    a_redirect_pc = 16'h0000; a_out_ready = 1'b1;
    b_reset = 1'b1; b_pc_write_en = 1'b1; b_out_ready = 1'b1;

    step; @(negedge clk);
    chk("rst_out_valid", 16'(a_out_valid), 16'h0);
    chk("rst_instruction", a_instruction, 16'h0000);
    chk("rst_imem_req", 16'(a_imem_req), 16'h0);

    step; a_reset = 1'b0; @(negedge clk);
    chk("first_req", 16'(a_imem_req), 16'h1);
    chk("first_addr", a_imem_addr, 16'h0000);

    step; @(negedge clk);
    chk("lat_out_valid", 16'(a_out_valid), 16'h0);
    chk("second_addr", a_imem_addr, 16'h0001);

    step; @(negedge clk);
    chk("first_pc_plus1", a_pc_plus1, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin step; @(negedge clk); end
      chk("stream_valid", 16'(a_out_valid), 16'h1);
      chk("stream_pc", a_instr_pc, 16'(i));
      chk("stream_instr", a_instruction, 16'(16'h1000 + i));
    end

    for (int j = 0; j < 5; j++) begin
      step; a_out_ready = 1'b0; @(negedge clk);
      chk("bp_req", 16'(a_imem_req), 16'h0);
      chk("bp_valid", 16'(a_out_valid), 16'h1);
      chk("bp_pc", a_instr_pc, 16'h000A);
      chk("bp_instr", a_instruction, 16'h100A);
    end
    chk("bp_count", 16'(dut_a.u_queue.count_q), 16'h2);

    step; a_out_ready = 1'b1; @(negedge clk);
    chk("bp_resume_req", 16'(a_imem_req), 16'h1);
    chk("bp_resume_addr", a_imem_addr, 16'h000C);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin step; @(negedge clk); end
      chk("resume_pc", a_instr_pc, 16'(10 + k));
      chk("resume_instr", a_instruction, 16'(16'h100A + k));
    end

    step; a_redirect_valid = 1'b1; a_redirect_pc = 16'h0040; @(negedge clk);
    chk("redir_inflight", 16'(dut_a.inflight_q), 16'h1);
    chk("redir_req", 16'(a_imem_req), 16'h0);
    chk("redir_pop_pc", a_instr_pc, 16'h0010);

    step; a_redirect_valid = 1'b0; @(negedge clk);
    chk("redir_n1_valid", 16'(a_out_valid), 16'h0);
    chk("redir_n1_req", 16'(a_imem_req), 16'h1);
    chk("redir_n1_addr", a_imem_addr, 16'h0040);

    step; @(negedge clk);
    chk("redir_n2_valid", 16'(a_out_valid), 16'h0);
    chk("redir_n2_addr", a_imem_addr, 16'h0041);

    for (int k = 0; k < 3; k++) begin
      step; @(negedge clk);
      chk("redir_valid", 16'(a_out_valid), 16'h1);
      chk("redir_pc", a_instr_pc, 16'(16'h0040 + k));
      chk("redir_instr", a_instruction, 16'(16'h1040 + k));
    end

    step; a_reset = 1'b1; @(negedge clk);
    chk("mid_rst_inflight", 16'(dut_a.inflight_q), 16'h1);
    chk("mid_rst_req", 16'(a_imem_req), 16'h0);

    step; a_reset = 1'b0; @(negedge clk);
    chk("mid_rst_valid", 16'(a_out_valid), 16'h0);
    chk("mid_rst_instr", a_instruction, 16'h0000);
    chk("restart_req", 16'(a_imem_req), 16'h1);
    chk("restart_addr", a_imem_addr, 16'h0000);

    step; @(negedge clk);
    chk("stale_dropped", 16'(a_out_valid), 16'h0);

    step; @(negedge clk);
    chk("restart_valid", 16'(a_out_valid), 16'h1);
    chk("restart_pc", a_instr_pc, 16'h0000);
    chk("restart_instr", a_instruction, 16'h1000);

    step; b_reset = 1'b0; @(negedge clk);
    chk("wrap_req0", 16'(b_imem_req), 16'h1);
    chk("wrap_addr0", b_imem_addr, 16'hFFFF);

    step; @(negedge clk);
    chk("wrap_addr1", b_imem_addr, 16'h0000);
    chk("wrap_valid1", 16'(b_out_valid), 16'h0);

    step; b_pc_write_en = 1'b0; @(negedge clk);
    chk("wrap_pc_ffff", b_instr_pc, 16'hFFFF);
    chk("wrap_instr_ffff", b_instruction, 16'h0FFF);
    chk("wrap_pc_plus1", b_pc_plus1, 16'h0000);
    chk("frz_req_a", 16'(b_imem_req), 16'h0);
    chk("frz_addr_a", b_imem_addr, 16'h0001);

    step; @(negedge clk);
    chk("wrap_pc_0000", b_instr_pc, 16'h0000);
    chk("wrap_instr_0000", b_instruction, 16'h1000);
    chk("frz_req_b", 16'(b_imem_req), 16'h0);
    chk("frz_addr_b", b_imem_addr, 16'h0001);

    step; @(negedge clk);
    chk("frz_valid_c", 16'(b_out_valid), 16'h0);
    chk("frz_req_c", 16'(b_imem_req), 16'h0);
    chk("frz_addr_c", b_imem_addr, 16'h0001);

    step; b_pc_write_en = 1'b1; @(negedge clk);
    chk("unfrz_req", 16'(b_imem_req), 16'h1);
    chk("unfrz_addr", b_imem_addr, 16'h0001);

    step; @(negedge clk);
    chk("unfrz_addr2", b_imem_addr, 16'h0002);

    step; @(negedge clk);
    chk("unfrz_valid", 16'(b_out_valid), 16'h1);
    chk("unfrz_pc", b_instr_pc, 16'h0001);
    chk("unfrz_instr", b_instruction, 16'h1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the 16-bit vector ASIP pipeline, on the producer side of the instruction interface that the decoder stage consumes.
- Generates the PC and issues reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump) and a PC write-enable from the hazard logic.

Parameters:
- ADDR_W, 16, instruction-memory word-address width (one 16-bit instruction per word).
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, output queue entries (fixed at 2; other values are not required to be supported).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_write_en  in  1  1 = fetch may advance; 0 = no new imem_req and PC frozen.
- redirect_valid  in  1  load redirect_pc and squash all fetched or in-flight instructions.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req  out  1  instruction-memory read strobe.
- imem_addr  out  ADDR_W  read address, equal to the PC register.
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_req.
- out_valid  out  1  instruction and pc outputs are valid.
- out_ready  in  1  decoder accepts this cycle (low = decode stall).
- instruction  out  INSTR_W  instruction to decode; NOP_INSTR when out_valid=0.
- instr_pc  out  ADDR_W  address of the presented instruction.
- pc_plus1  out  ADDR_W  instr_pc+1, wrapping modulo 2^ADDR_W.

Behaviour:
State:
- pc register.
- inflight bit: imem_req was issued last cycle.
- squash bit: discard the response now arriving.
- queue of {instr, pc}, count 0..2.

Rules:
- Pop: out_valid && out_ready; out_valid = (count != 0).
- Issue: imem_req = pc_write_en && !redirect_valid && !reset && (count + inflight - pop < DEPTH). The queue never overflows.
- On issue: pc <= pc+1, wrapping from 2^ADDR_W-1 to 0; inflight <= 1. Otherwise inflight <= 0 and pc holds.
- Response: when inflight && !squash, push {imem_rdata, address issued} into the queue the same cycle the data arrives. The instruction becomes visible on out_* the next cycle.
- Push and pop may occur in the same cycle; count is unchanged and order is preserved (FIFO).

Latency:
- Issue at cycle N gives data at N+1 and out_valid at N+2 when the queue was empty.
- Steady-state throughput is 1 instruction/cycle with out_ready=1.

Redirect at cycle N:
- Queue cleared and pc <= redirect_pc.
- squash <= inflight, so the response arriving at N+1 is dropped.
- No issue at N; first issue at N+1 with imem_addr = redirect_pc; out_valid at N+3 earliest.
- A pop handshake completing at N counts as accepted; killing it is the redirecting stage's responsibility.
- Redirect takes priority over pc_write_en=0: pc is still loaded.

Reset (any cycle, including mid-operation):
- Next cycle: pc=RESET_PC, count=0, inflight=0, squash=0.
- Outputs: out_valid=0, imem_req=0, instruction=NOP_INSTR.
- The response to a request issued before reset is ignored.

Other rules:
- pc_write_en=0 does not block pops or the landing of an in-flight response.
- With out_ready held low: at most 2 entries are stored and imem_req stays 0 until space is freed.
- instruction, instr_pc and pc_plus1 come from the queue head. They must hold stable while out_valid && !out_ready.

Decomposition:
- Package asip_fetch_pkg: ADDR_W and INSTR_W defaults, NOP_INSTR = 16'h0000, and the struct fetch_entry_t {instr, pc}.
- Sub-module fetch_queue holds the 2-entry synchronous FIFO of fetch_entry_t. It has push, pop, flush, count, and head outputs; flush has priority over push.
- fetch_stage holds the PC, issue/credit logic, inflight/squash bits, and the output mapping.

Test Plan:
1. Reset sequence:
   - Stimulus: reset high 2 cycles then low; memory returns data = 16'h1000 + addr.
   - Response: first cycle after reset, imem_req=1 and imem_addr=0x0000; two cycles later out_valid=1, instruction=0x1000, instr_pc=0, pc_plus1=1.
2. Streaming:
   - Stimulus: out_ready=1 continuously for 10 cycles.
   - Response: out_* shows instr_pc 0,1,2,…,9 on consecutive cycles with instruction = 0x1000+pc; no bubbles after the first.
3. Backpressure:
   - Stimulus: drop out_ready for 5 cycles mid-stream.
   - Response: imem_req drops within one cycle, count never exceeds 2, and outputs hold stable. After release the sequence resumes with no gap, no duplicate and no loss.
4. Redirect with request in flight:
   - Stimulus: redirect_valid with redirect_pc=0x0040 while inflight=1 and the queue is full.
   - Response: next imem_addr=0x0040. The next accepted instr_pc is 0x0040, instruction=0x1040; no pre-redirect pc appears after the redirect cycle.
5. Wrap and freeze:
   - Stimulus: RESET_PC=16'hFFFF; later, pc_write_en=0 for 3 cycles.
   - Response: instr_pc sequence FFFF, 0000 (pc_plus1 at FFFF = 0000). While frozen, imem_req=0 and the pc holds; resumes afterwards without skipping.
6. Reset mid-operation:
   - Stimulus: with a full queue and inflight=1, assert reset for 1 cycle.
   - Response: next cycle out_valid=0, instruction=0x0000, imem_req=0. After release, fetch restarts at RESET_PC and the stale response is never output.
